trail_collision_detector: RTL and testbench
===========================================

// Module: trail_collision_detector
// PURPOSE
//  Downstream of the head-position datapath.
//  - Keeps a 1-bit "visited" map of the 160x120 playfield.
//  - On each new head position it reports whether the head hit a wall or its own trail.
//  - Marks the position as visited.
//  - The top-level control FSM uses the collision output to stop the game.
// PARAMETERS
//  H_RES   160  playfield width in pixels
//  V_RES   120  playfield height in pixels
//  ADDR_W  15   visited-map address width (ceil(log2(H_RES*V_RES)))
// PORTS
//  clk        in   1  system clock (CLOCK_50)
//  resetn     in   1  asynchronous, active-low reset
//  clear      in   1  1-cycle pulse: wipe visited map, clear collision flags
//  plot_req   in   1  1-cycle pulse: x/y hold a new head position
//  x          in   8  head x (datapath x_out)
//  y          in   7  head y (datapath y_out)
//  busy       out  1  high when not in S_IDLE; plot_req is ignored while busy
//  done       out  1  1-cycle pulse: check of the accepted plot_req complete
//  hit_wall   out  1  sticky: a head position was outside the playfield
//  hit_trail  out  1  sticky: a head position was already visited
//  collision  out  1  hit_wall | hit_trail
// BEHAVIOUR
//  - Map storage
//    - H_RES*V_RES x 1 bit, synchronous read, one read or write port per cycle.
//    - addr = y*160 + x, computed as (y<<7)+(y<<5)+x at ADDR_W bits.
//    - Map contents are not reset; the clear sweep initialises them.
//  - Async reset
//    - state=S_CLEAR, sweep addr=0.
//    - done=0, hit_wall=0, hit_trail=0, collision=0, busy=1.
//  - FSM states: S_CLEAR, S_IDLE, S_READ, S_CHECK, S_DEAD
//    - S_CLEAR
//      - Writes 0 at sweep addr, addr++ each cycle.
//      - After writing addr H_RES*V_RES-1, goes to S_IDLE.
//      - The sweep takes exactly 19200 cycles; done is not pulsed.
//    - S_IDLE: on plot_req, latch x/y/addr and go to S_READ.
//    - S_READ
//      - Out of bounds (x>=H_RES or y>=V_RES): no map access.
//      - Otherwise: issue a map read at the latched addr.
//      - Next state is S_CHECK.
//    - S_CHECK
//      - Out of bounds: set hit_wall, no write.
//      - Read bit = 1: set hit_trail; the bit stays 1.
//      - Read bit = 0: write 1 at addr.
//      - Pulse done.
//      - Next state is S_DEAD if collision is now set, else S_IDLE.
//    - S_DEAD: plot_req is ignored; done is never pulsed; stays until clear.
//  - clear handling
//    - clear in any state (including mid-sweep): next state S_CLEAR, sweep addr=0.
//    - hit_wall, hit_trail and collision go to 0 the cycle after clear.
//    - Any in-flight check is aborted with no done and no write.
//  - Latency: plot_req accepted at cycle N -> done at N+2; flags valid at N+2.
//  - plot_req arriving when busy=1 is dropped; there is no queue.
//  - clear and plot_req in the same cycle: clear wins; plot_req is dropped.
//  - Wrap-around from the datapath (counters are not clamped)
//    - x decrement below 0 gives 255, which is >=160, so hit_wall.
//    - y decrement below 0 gives 127, which is >=120, so hit_wall.
//  - Corner pixels (0,0)=addr 0 and (159,119)=addr 19199 are valid and must not alias.
// TESTING
//  1. Release reset: busy=1 for 19200 cycles, then 0. plot_req (0,60) -> done at N+2, collision=0.
//  2. plot_req (10,20), then plot_req (10,20) again -> second done has hit_trail=1, collision=1, hit_wall=0.
//  3. Separate runs with plot_req (160,5), (255,60), (30,127) -> hit_wall=1 each run; map unchanged (replot (0,5) gives no hit).
//  4. After a collision, plot_req (1,1) -> no done. Pulse clear -> flags 0 next cycle, busy for 19200 cycles; replot (10,20) -> no hit.
//  5. plot_req at N and N+1 -> only the first is accepted. clear with plot_req in the same cycle -> sweep starts, no done.
//  6. plot_req (0,0), then (159,119), then (0,0) -> hits only on the third request; clear issued mid-sweep restarts the full 19200-cycle sweep.

Source files
------------

// File: rtl/trail_collision_detector.sv
// Visited-map collision checker for the trail game: a 1-bit map of the playfield.
// Each accepted head position is tested for wall/trail hits and then marked as visited.
module trail_collision_detector #(
  parameter int H_RES  = 160,
  parameter int V_RES  = 120,
  parameter int ADDR_W = 15
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       clear,
  input  logic       plot_req,
  input  logic [7:0] x,
  input  logic [6:0] y,
  output logic       busy,
  output logic       done,
  output logic       hit_wall,
  output logic       hit_trail,
  output logic       collision
);

  localparam int unsigned         MAP_DEPTH = H_RES * V_RES;
  localparam logic [ADDR_W-1:0]   LAST_ADDR = ADDR_W'(MAP_DEPTH - 1);

  typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_READ, S_CHECK, S_DEAD} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   sweep_q, sweep_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                oob_q, oob_d;
  logic                done_q, done_d;
  logic                wall_q, wall_d;
  logic                trail_q, trail_d;

  logic [ADDR_W-1:0]   addr_calc;
  logic                oob_calc;

  logic                map_we, map_re, map_wd, rd_q;
  logic [ADDR_W-1:0]   map_addr;
  logic                map_mem [MAP_DEPTH];

  // y*160 as shift-and-add; only meaningful when the position is in bounds
  assign addr_calc = (ADDR_W'(y) << 7) + (ADDR_W'(y) << 5) + ADDR_W'(x);
  assign oob_calc  = (32'(x) >= 32'(H_RES)) || (32'(y) >= 32'(V_RES));

  // Single-port map, synchronous read; contents are initialised by the sweep
  always_ff @(posedge clk) begin
    if (map_we) map_mem[map_addr] <= map_wd;
    if (map_re) rd_q <= map_mem[map_addr];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_CLEAR;
      sweep_q <= '0;
      addr_q  <= '0;
      oob_q   <= 1'b0;
      done_q  <= 1'b0;
      wall_q  <= 1'b0;
      trail_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      addr_q  <= addr_d;
      oob_q   <= oob_d;
      done_q  <= done_d;
      wall_q  <= wall_d;
      trail_q <= trail_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sweep_d  = sweep_q;
    addr_d   = addr_q;
    oob_d    = oob_q;
    done_d   = 1'b0;
    wall_d   = wall_q;
    trail_d  = trail_q;
    map_we   = 1'b0;
    map_re   = 1'b0;
    map_wd   = 1'b0;
    map_addr = addr_q;
    // clear overrides everything, aborting any check before its write
    if (clear) begin
      state_d = S_CLEAR;
      sweep_d = '0;
      wall_d  = 1'b0;
      trail_d = 1'b0;
    end else begin
      case (state_q)
        S_CLEAR: begin
          map_we   = 1'b1;
          map_addr = sweep_q;
          sweep_d  = sweep_q + 1'b1;
          if (sweep_q == LAST_ADDR) begin
            state_d = S_IDLE;
            sweep_d = '0;
          end
        end
        S_IDLE: begin
          if (plot_req) begin
            addr_d  = addr_calc;
            oob_d   = oob_calc;
            state_d = S_READ;
          end
        end
        S_READ: begin
          map_re  = !oob_q;
          state_d = S_CHECK;
        end
        S_CHECK: begin
          done_d = 1'b1;
          if (oob_q) begin
            wall_d = 1'b1;
          end else if (rd_q) begin
            trail_d = 1'b1;
          end else begin
            map_we = 1'b1;
            map_wd = 1'b1;
          end
          state_d = (oob_q || rd_q) ? S_DEAD : S_IDLE;
        end
        S_DEAD: begin
          state_d = S_DEAD;
        end
        default: state_d = S_CLEAR;
      endcase
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign hit_wall  = wall_q;
  assign hit_trail = trail_q;
  assign collision = wall_q | trail_q;

endmodule

// File: tb/tb_trail_collision_detector.sv
// Bench for trail_collision_detector: a cycle-level reference model tracks sweep time,
// pending checks and the visited set, and the DUT outputs are compared against it every cycle.
module tb_trail_collision_detector;
  logic       clk = 1'b0, resetn = 1'b0, clear = 1'b0, plot_req = 1'b0;
  logic [7:0] x = '0;
  logic [6:0] y = '0;
  logic       busy, done, hit_wall, hit_trail, collision;
  int         n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  trail_collision_detector dut (
    .clk(clk), .resetn(resetn), .clear(clear), .plot_req(plot_req),
    .x(x), .y(y), .busy(busy), .done(done), .hit_wall(hit_wall),
    .hit_trail(hit_trail), .collision(collision)
  );

  // Reference model: remaining sweep cycles, cycles until the pending check resolves,
  // and the set of visited pixels.
  bit vis [0:19199];
  int m_sweep, m_pend, m_px, m_py;
  bit m_wall, m_trail, m_dead, m_done;

  function automatic bit m_busy();
    return (m_sweep > 0) || (m_pend > 0) || m_dead;
  endfunction

  task automatic model_reset();
    m_sweep = 19200; m_pend = 0; m_wall = 0; m_trail = 0; m_dead = 0; m_done = 0;
  endtask

  task automatic model_step();
    m_done = 0;
    if (clear) begin
      model_reset();
      foreach (vis[i]) vis[i] = 0;
    end else if (m_sweep > 0) begin
      m_sweep--;
    end else if (m_pend > 0) begin
      m_pend--;
      if (m_pend == 0) begin
        m_done = 1;
        if (m_px >= 160 || m_py >= 120) m_wall = 1;
        else if (vis[m_py*160 + m_px]) m_trail = 1;
        else vis[m_py*160 + m_px] = 1;
        if (m_wall || m_trail) m_dead = 1;
      end
    end else if (!m_dead && plot_req) begin
      m_pend = 2; m_px = int'(x); m_py = int'(y);
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!resetn) model_reset();
      else model_step();
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("cyc_busy", busy, m_busy());
    check("cyc_done", done, m_done);
    check("cyc_hit_wall", hit_wall, m_wall);
    check("cyc_hit_trail", hit_trail, m_trail);
    check("cyc_collision", collision, m_wall | m_trail);
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic plot(input int px, input int py, input bit e_done, input bit e_wall,
                      input bit e_trail, input string nm);
    x = 8'(px); y = 7'(py); plot_req = 1'b1;
    cyc();
    plot_req = 1'b0;
    cyc(); cyc();
    check({nm, "_done"}, done, e_done);
    check({nm, "_wall"}, hit_wall, e_wall);
    check({nm, "_trail"}, hit_trail, e_trail);
    check({nm, "_collision"}, collision, e_wall | e_trail);
  endtask

  task automatic wait_sweep(input string nm);
    int n;
    n = 0;
    while (busy && n < 20000) begin cyc(); n++; end
    check(nm, n, 19200);
  endtask

  task automatic pulse_clear(input string nm);
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    check({nm, "_busy"}, busy, 1);
    check({nm, "_collision"}, collision, 0);
    check({nm, "_hit_trail"}, hit_trail, 0);
    check({nm, "_hit_wall"}, hit_wall, 0);
  endtask

  initial begin
    int px, py;
    #2;
    check("rst_busy", busy, 1);
    check("rst_done", done, 0);
    check("rst_collision", collision, 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    wait_sweep("reset_sweep_len");

    // Run A: first plots, corners distinct, repeat hits trail, dead ignores plots
    plot(0, 60, 1, 0, 0, "t1_first");
    plot(0, 0, 1, 0, 0, "corner_lo");
    plot(159, 119, 1, 0, 0, "corner_hi");
    plot(10, 20, 1, 0, 0, "t2_first");
    plot(10, 20, 1, 0, 1, "t2_repeat");
    plot(1, 1, 0, 0, 1, "t4_dead_plot");
    pulse_clear("t4_clear");
    wait_sweep("clear_sweep_len");

    // Run B: map wiped, back-to-back drop, random plots on fresh pixels, wall at x=160
    plot(10, 20, 1, 0, 0, "t4_replot");
    plot(0, 0, 1, 0, 0, "corner_lo_again");
    x = 8'd50; y = 7'd50; plot_req = 1'b1;
    cyc();
    x = 8'd51; y = 7'd51;
    cyc();
    plot_req = 1'b0;
    cyc();
    check("b2b_first_done", done, 1);
    plot(51, 51, 1, 0, 0, "b2b_second_dropped");
    repeat (400) begin
      px = $urandom_range(159);
      py = $urandom_range(119);
      x = 8'(px); y = 7'(py);
      plot_req = vis[py*160 + px] ? 1'b0 : ($urandom_range(2) == 0);
      cyc();
    end
    plot_req = 1'b0;
    cyc(); cyc(); cyc();
    plot(160, 5, 1, 1, 0, "t3_wall_x160");

    // clear and plot together: clear wins; then clear again mid-sweep
    clear = 1'b1; plot_req = 1'b1; x = 8'd70; y = 7'd70;
    cyc();
    clear = 1'b0; plot_req = 1'b0;
    check("clr_plot_busy", busy, 1);
    check("clr_plot_collision", collision, 0);
    repeat (40) cyc();
    pulse_clear("midsweep_clear");
    wait_sweep("midsweep_restart_len");

    // Run C
    plot(0, 5, 1, 0, 0, "t3_replot_0_5");
    plot(70, 70, 1, 0, 0, "clr_plot_was_dropped");
    plot(255, 60, 1, 1, 0, "t3_wall_x255");
    pulse_clear("t3_clear");
    wait_sweep("clear_sweep2_len");

    // Run D
    plot(30, 127, 1, 1, 0, "t3_wall_y127");
    plot(2, 2, 0, 1, 0, "dead_after_wall");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
